// File: rtl/gate_boy_pkg.sv
// Shared types and constants for the ALU controller slice: widths, opcode and
// register index encodings, flag bit positions, post-boot register values, FSM states.
package gate_boy_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int OPCODE_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_AND = 3'd4,
        OP_XOR = 3'd5,
        OP_OR  = 3'd6,
        OP_CP  = 3'd7
    } alu_op_e;

    // Slot 6 doubles as the F storage slot inside the register file.
    typedef enum logic [2:0] {
        REG_B   = 3'd0,
        REG_C   = 3'd1,
        REG_D   = 3'd2,
        REG_E   = 3'd3,
        REG_H   = 3'd4,
        REG_L   = 3'd5,
        REG_IMM = 3'd6,
        REG_A   = 3'd7
    } reg_idx_e;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    localparam logic [DATA_WIDTH-1:0] REG_RESET_A = 8'h01;
    localparam logic [DATA_WIDTH-1:0] REG_RESET_F = 8'hB0;
    localparam logic [DATA_WIDTH-1:0] REG_RESET_B = 8'h00;
    localparam logic [DATA_WIDTH-1:0] REG_RESET_C = 8'h13;
    localparam logic [DATA_WIDTH-1:0] REG_RESET_D = 8'h00;
    localparam logic [DATA_WIDTH-1:0] REG_RESET_E = 8'hD8;
    localparam logic [DATA_WIDTH-1:0] REG_RESET_H = 8'h01;
    localparam logic [DATA_WIDTH-1:0] REG_RESET_L = 8'h4D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } alu_ctrl_state_e;

endpackage

// File: rtl/gb_regfile.sv
// 8-bit register file (A,F,B,C,D,E,H,L) with an external load port and an ALU writeback port.
// ALU_CTRL_DBG_EN adds a second combinational read port (index 6 reads F).
module gb_regfile
    import gate_boy_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ext_we,
    input  reg_idx_e              ext_idx,
    input  logic [DATA_WIDTH-1:0] ext_data,
    input  logic                  wb_we,
    input  logic                  wb_write_a,
    input  logic [DATA_WIDTH-1:0] wb_a,
    input  logic [3:0]            wb_flags,
    input  reg_idx_e              rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] reg_a,
    output logic                  flag_c
`ifdef ALU_CTRL_DBG_EN
    ,
    input  reg_idx_e              dbg_idx,
    output logic [DATA_WIDTH-1:0] dbg_data
`endif
);

    logic [DATA_WIDTH-1:0] regs [8];

    // External writes and writeback are never active together (IDLE vs WB),
    // so their order here carries no priority meaning.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs[REG_B]   <= REG_RESET_B;
            regs[REG_C]   <= REG_RESET_C;
            regs[REG_D]   <= REG_RESET_D;
            regs[REG_E]   <= REG_RESET_E;
            regs[REG_H]   <= REG_RESET_H;
            regs[REG_L]   <= REG_RESET_L;
            regs[REG_IMM] <= REG_RESET_F;
            regs[REG_A]   <= REG_RESET_A;
        end else begin
            if (ext_we && (ext_idx != REG_IMM)) begin
                regs[ext_idx] <= ext_data;
            end
            if (wb_we) begin
                if (wb_write_a) begin
                    regs[REG_A] <= wb_a;
                end
                regs[REG_IMM] <= {wb_flags, 4'b0000};
            end
        end
    end

    assign rd_data = regs[rd_idx];
    assign reg_a   = regs[REG_A];
    assign flag_c  = regs[REG_IMM][FLAG_C];

`ifdef ALU_CTRL_DBG_EN
    assign dbg_data = regs[dbg_idx];
`endif

endmodule

// File: rtl/alu_ctrl.sv
// ALU initiator: accepts decoded ALU instructions and sequences READ -> EXEC -> WB.
// Optional register read-back port enabled by ALU_CTRL_DBG_EN.
module alu_ctrl
    import gate_boy_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [2:0]              instr_op,
    input  logic [2:0]              instr_src,
    input  logic [DATA_WIDTH-1:0]   instr_imm,
    input  logic                    reg_wr_en,
    input  logic [2:0]              reg_wr_idx,
    input  logic [DATA_WIDTH-1:0]   reg_wr_data,
    output logic [DATA_WIDTH-1:0]   alu_operand_a,
    output logic [DATA_WIDTH-1:0]   alu_operand_b,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic                    alu_carry_in,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [3:0]              alu_flags,
    output logic                    done,
    output alu_ctrl_state_e         state_dbg
`ifdef ALU_CTRL_DBG_EN
    ,
    input  logic [2:0]              dbg_sel,
    output logic [DATA_WIDTH-1:0]   dbg_data
`endif
);

    // Handshake: an instruction transfers on a rising clk edge where
    // instr_valid && instr_ready; fields must stay stable until then.

    localparam logic [1:0] LAT_INIT = 2'(ALU_LATENCY - 1);

    alu_ctrl_state_e       state, state_nxt;
    alu_op_e               op_q;
    reg_idx_e              src_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [1:0]            lat_cnt;
    logic                  accept;
    logic                  wb_we;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] reg_a;
    logic                  flag_c;
    logic [DATA_WIDTH-1:0] src_val;

    assign instr_ready = (state == ST_IDLE) && rst_n;
    assign accept      = instr_valid && instr_ready;
    assign src_val     = (src_q == REG_IMM) ? imm_q : rd_data;
    assign state_dbg   = state;

    gb_regfile u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .ext_we     (reg_wr_en && (state == ST_IDLE)),
        .ext_idx    (reg_idx_e'(reg_wr_idx)),
        .ext_data   (reg_wr_data),
        .wb_we      (wb_we),
        .wb_write_a (op_q != OP_CP),
        .wb_a       (alu_result),
        .wb_flags   (alu_flags),
        .rd_idx     (src_q),
        .rd_data    (rd_data),
        .reg_a      (reg_a),
        .flag_c     (flag_c)
`ifdef ALU_CTRL_DBG_EN
        ,
        .dbg_idx    (reg_idx_e'(dbg_sel)),
        .dbg_data   (dbg_data)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_q          <= OP_ADD;
            src_q         <= REG_B;
            imm_q         <= '0;
            lat_cnt       <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_opcode    <= '0;
            alu_carry_in  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= alu_op_e'(instr_op);
                src_q <= reg_idx_e'(instr_src);
                imm_q <= instr_imm;
            end
            // Operands are captured once per instruction and held until the next READ.
            if (state == ST_READ) begin
                alu_operand_a <= reg_a;
                alu_operand_b <= src_val;
                alu_opcode    <= {{(OPCODE_WIDTH-3){1'b0}}, op_q};
                alu_carry_in  <= flag_c;
                lat_cnt       <= LAT_INIT;
            end else if ((state == ST_EXEC) && (lat_cnt != 2'd0)) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wb_we     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: if (lat_cnt == 2'd0) state_nxt = ST_WB;
            ST_WB: begin
                wb_we     = rst_n;
                done      = rst_n;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a registered one-cycle ALU model and a done-driven scoreboard.
module tb_alu_ctrl;
    import gate_boy_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [2:0]              instr_op;
    logic [2:0]              instr_src;
    logic [7:0]              instr_imm;
    logic                    reg_wr_en;
    logic [2:0]              reg_wr_idx;
    logic [7:0]              reg_wr_data;
    logic [7:0]              alu_operand_a;
    logic [7:0]              alu_operand_b;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic                    alu_carry_in;
    logic [7:0]              alu_result;
    logic [3:0]              alu_flags;
    logic                    done;
    alu_ctrl_state_e         state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    // {op_a, op_b, opcode, carry_in, A_after, F_after}
    logic [36:0] exp_q[$];
    logic [36:0] cur;
    logic        chk_after = 1'b0;

    alu_ctrl #(.ALU_LATENCY(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_src     (instr_src),
        .instr_imm     (instr_imm),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_idx    (reg_wr_idx),
        .reg_wr_data   (reg_wr_data),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_opcode    (alu_opcode),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .done          (done),
        .state_dbg     (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: {result, Z, N, H, C}
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] op, input logic c);
        logic [8:0] r;
        logic n, h, cy;
        r = '0; n = 1'b0; h = 1'b0; cy = 1'b0;
        case (op[2:0])
            3'd0: begin
                r  = {1'b0, a} + {1'b0, b};
                h  = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
                cy = r[8];
            end
            3'd1: begin
                r  = {1'b0, a} + {1'b0, b} + {8'd0, c};
                h  = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c}) > 5'd15;
                cy = r[8];
            end
            3'd2, 3'd7: begin
                r  = {1'b0, a} - {1'b0, b};
                n  = 1'b1;
                h  = a[3:0] < b[3:0];
                cy = a < b;
            end
            3'd3: begin
                r  = {1'b0, a} - {1'b0, b} - {8'd0, c};
                n  = 1'b1;
                h  = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'd0, c});
                cy = {1'b0, a} < ({1'b0, b} + {8'd0, c});
            end
            3'd4: begin r = {1'b0, a & b}; h = 1'b1; end
            3'd5: r = {1'b0, a ^ b};
            default: r = {1'b0, a | b};
        endcase
        return {r[7:0], (r[7:0] == 8'd0), n, h, cy};
    endfunction

    always @(posedge clk) begin
        {alu_result, alu_flags} <= alu_model(alu_operand_a, alu_operand_b, alu_opcode, alu_carry_in);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] opc,
                            input logic cin, input logic [7:0] a_new, input logic [7:0] f_new);
        exp_q.push_back({a, b, opc, cin, a_new, f_new});
    endtask

    task automatic wait_ready(input string name);
        int g;
        g = 0;
        while (!instr_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!instr_ready) check({name, "_ready_timeout"}, 16'(instr_ready), 16'd1);
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] src, input logic [7:0] imm);
        instr_op    = op;
        instr_src   = src;
        instr_imm   = imm;
        instr_valid = 1'b1;
        wait_ready("send");
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        reg_wr_en   = 1'b0;
    endtask

    task automatic reg_write(input logic [2:0] idx, input logic [7:0] data);
        wait_ready("regwr");
        reg_wr_en   = 1'b1;
        reg_wr_idx  = idx;
        reg_wr_data = data;
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (chk_after) begin
            chk_after = 1'b0;
            check("wb_A", 16'(dut.u_rf.regs[7]), 16'(cur[15:8]));
            check("wb_F", 16'(dut.u_rf.regs[6]), 16'(cur[7:0]));
            check("done_single", 16'(done), 16'd0);
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 16'(done), 16'd0);
            end else begin
                cur = exp_q.pop_front();
                check("operand_a", 16'(alu_operand_a), 16'(cur[36:29]));
                check("operand_b", 16'(alu_operand_b), 16'(cur[28:21]));
                check("opcode",    16'(alu_opcode),    16'(cur[20:17]));
                check("carry_in",  16'(alu_carry_in),  16'(cur[16]));
                chk_after = 1'b1;
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_src   = '0;
        instr_imm   = '0;
        reg_wr_en   = 1'b0;
        reg_wr_idx  = '0;
        reg_wr_data = '0;

        // 1. reset values
        repeat (3) @(negedge clk);
        check("ready_in_reset", 16'(instr_ready), 16'd0);
        check("opa_reset",  16'(alu_operand_a), 16'h00);
        check("opc_reset",  16'(alu_opcode), 16'h0);
        check("cin_reset",  16'(alu_carry_in), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 16'(instr_ready), 16'd1);
        check("state_after_reset", 16'(state_dbg), 16'(ST_IDLE));
        check("rst_A", 16'(dut.u_rf.regs[7]), 16'h01);
        check("rst_F", 16'(dut.u_rf.regs[6]), 16'hB0);
        check("rst_C", 16'(dut.u_rf.regs[1]), 16'h13);
        check("rst_E", 16'(dut.u_rf.regs[3]), 16'hD8);
        check("rst_L", 16'(dut.u_rf.regs[5]), 16'h4D);

        // 2. B=0F written in the same cycle as ADD A,B is accepted
        push_exp(8'h01, 8'h0F, 4'd0, 1'b1, 8'h10, 8'h20);
        reg_wr_en = 1'b1; reg_wr_idx = 3'd0; reg_wr_data = 8'h0F;
        send(3'd0, 3'd0, 8'h00);

        // 3. XOR A
        push_exp(8'h10, 8'h10, 4'd5, 1'b0, 8'h00, 8'h80);
        send(3'd5, 3'd7, 8'h00);

        // index 6 write is ignored; index 7 writes A
        reg_write(3'd6, 8'hFF);
        reg_write(3'd7, 8'h01);
        @(negedge clk);
        check("idx6_ignored_F", 16'(dut.u_rf.regs[6]), 16'h80);
        check("idx7_writes_A",  16'(dut.u_rf.regs[7]), 16'h01);

        // 4. CP IMM 01
        push_exp(8'h01, 8'h01, 4'd7, 1'b0, 8'h01, 8'hC0);
        send(3'd7, 3'd6, 8'h01);

        // 5. valid held high across two instructions
        push_exp(8'h01, 8'hFF, 4'd0, 1'b0, 8'h00, 8'hB0);
        instr_op = 3'd0; instr_src = 3'd6; instr_imm = 8'hFF; instr_valid = 1'b1;
        wait_ready("held1");
        @(posedge clk); #1;
        push_exp(8'h00, 8'h0F, 4'd1, 1'b1, 8'h10, 8'h20);
        instr_op = 3'd1; instr_src = 3'd0; instr_imm = 8'h00;
        @(negedge clk);
        check("busy_n1", 16'(instr_ready), 16'd0);
        check("state_read", 16'(state_dbg), 16'(ST_READ));
        @(posedge clk); #1;
        reg_wr_en = 1'b1; reg_wr_idx = 3'd0; reg_wr_data = 8'h55;
        @(negedge clk);
        check("busy_n2", 16'(instr_ready), 16'd0);
        @(posedge clk); #1;
        reg_wr_en = 1'b0;
        @(negedge clk);
        check("busy_n3", 16'(instr_ready), 16'd0);
        @(negedge clk);
        check("ready_n4", 16'(instr_ready), 16'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;

        // remaining opcodes
        push_exp(8'h10, 8'h13, 4'd2, 1'b0, 8'hFD, 8'h70);
        send(3'd2, 3'd1, 8'h00);
        push_exp(8'hFD, 8'hFC, 4'd3, 1'b1, 8'h00, 8'hC0);
        send(3'd3, 3'd6, 8'hFC);
        push_exp(8'h00, 8'h4D, 4'd6, 1'b0, 8'h4D, 8'h00);
        send(3'd6, 3'd5, 8'h00);
        push_exp(8'h4D, 8'hD8, 4'd4, 1'b0, 8'h48, 8'h20);
        send(3'd4, 3'd3, 8'h00);
        wait_ready("pre_abort");
        @(negedge clk);
        check("B_not_overwritten", 16'(dut.u_rf.regs[0]), 16'h0F);

        // 6. reset during EXEC aborts the instruction
        send(3'd0, 3'd0, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("ready_abort_reset", 16'(instr_ready), 16'd0);
        check("opa_abort_reset", 16'(alu_operand_a), 16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_A", 16'(dut.u_rf.regs[7]), 16'h01);
        check("abort_F", 16'(dut.u_rf.regs[6]), 16'hB0);
        check("abort_ready", 16'(instr_ready), 16'd1);
        push_exp(8'h01, 8'h00, 4'd0, 1'b1, 8'h01, 8'h00);
        send(3'd0, 3'd2, 8'h00);

        for (int i = 0; i < 50 && (exp_q.size() != 0 || chk_after); i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 16'(exp_q.size()), 16'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
